// File: rtl/cam_avg_multi.sv
// -----------------------------------------------------------------------------
// cam_avg_multi
//
// Frame-average engine for the camera pixel path. Every valid pixel of each
// channel is summed over a V_SYNC-delimited frame. Every FRAMES_PER_UPD frames
// the completed frame's sums are snapshotted and divided by the pixel count
// with one shared restoring divider (one quotient bit per clock, channels in
// order 0..NUM_CH-1). The averages are published together, and the upd output
// toggles once for each published set.
//
// Optional feature (compile-time macro CAM_AVG_ROUND_EN):
//   defined   : dividend = sum + (count >> 1)  -> round-half-up
//   undefined : dividend = sum                 -> floor
//   Latency is the same in both builds.
//
// Ports:
//   VGA_CLK    in   pixel clock
//   RST_N      in   asynchronous active-low reset
//   V_SYNC     in   active-low vertical sync; its falling edge ends a frame
//   pix_valid  in   pixel qualifier
//   pixel      in   NUM_CH*PIX_W packed samples, channel 0 in the LSBs
//   color      out  NUM_CH*PIX_W packed averages, channel 0 in the LSBs
//   upd        out  toggles once per published average set
//   busy       out  divider running (DIV or DONE)
//   frame_err  out  sticky: a frame reached FRAME_PIX pixels before its end
//   overrun    out  sticky: an update fell due while busy and was dropped
// -----------------------------------------------------------------------------
module cam_avg_multi #(
    parameter int PIX_W          = 8,
    parameter int NUM_CH         = 3,
    parameter int FRAME_PIX      = 307200,
    parameter int FRAMES_PER_UPD = 30,
    parameter int ACC_W          = 32
) (
    input  logic                    VGA_CLK,
    input  logic                    RST_N,
    input  logic                    V_SYNC,
    input  logic                    pix_valid,
    input  logic [NUM_CH*PIX_W-1:0] pixel,
    output logic [NUM_CH*PIX_W-1:0] color,
    output logic                    upd,
    output logic                    busy,
    output logic                    frame_err,
    output logic                    overrun
);

    localparam int CNT_W = $clog2(FRAME_PIX + 1);
    localparam int FC_W  = (FRAMES_PER_UPD > 1) ? $clog2(FRAMES_PER_UPD) : 1;
    localparam int BIT_W = (ACC_W > 1) ? $clog2(ACC_W) : 1;
    localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    localparam logic [CNT_W-1:0] FRAME_PIX_C = CNT_W'(FRAME_PIX);
    localparam logic [FC_W-1:0]  FC_LAST     = FC_W'(FRAMES_PER_UPD - 1);
    localparam logic [BIT_W-1:0] BIT_LAST    = BIT_W'(ACC_W - 1);
    localparam logic [CH_W-1:0]  CH_LAST     = CH_W'(NUM_CH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_DIV  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t state_q, state_d;

    // Frame accumulation
    logic                    vs_q;
    logic [ACC_W-1:0]        acc_q   [NUM_CH];
    logic [CNT_W-1:0]        cnt_q;
    logic [FC_W-1:0]         fcnt_q;

    // Divider
    logic [ACC_W-1:0]        snap_q  [NUM_CH];   // dividends of the snapshotted frame
    logic [CNT_W-1:0]        div_cnt_q;          // divisor (pixel count of that frame)
    logic [ACC_W-1:0]        rem_q;
    logic [ACC_W-1:0]        quo_q;              // dividend shifts out, quotient shifts in
    logic [BIT_W-1:0]        bit_q;
    logic [CH_W-1:0]         ch_q;
    logic [ACC_W-1:0]        res_q   [NUM_CH];   // shadow quotients until DONE

    // Outputs
    logic [NUM_CH*PIX_W-1:0] color_q;
    logic                    upd_q;
    logic                    frame_err_q;
    logic                    overrun_q;

    // -------------------------------------------------------------------------
    // Combinational helpers
    // -------------------------------------------------------------------------
    logic                    boundary;
    logic                    upd_due;
    logic                    start_div;
    logic [PIX_W-1:0]        pix_ch  [NUM_CH];
    logic [ACC_W-1:0]        round_add;
    logic [ACC_W-1:0]        div_in  [NUM_CH];
    logic [ACC_W:0]          rem_shift;
    logic [ACC_W-1:0]        div_ext;
    logic                    rem_ge;
    logic [ACC_W-1:0]        rem_sub;
    logic [ACC_W-1:0]        rem_next;
    logic [ACC_W-1:0]        quo_next;
    logic                    last_bit;
    logic                    last_ch;
    logic [CH_W-1:0]         ch_nxt;

    assign boundary  = vs_q & ~V_SYNC;
    assign upd_due   = boundary && (fcnt_q == FC_LAST);
    // A frame without valid pixels has no average; it is silently skipped.
    assign start_div = upd_due && (state_q == S_IDLE) && (cnt_q != '0);
    assign busy      = (state_q != S_IDLE);

`ifdef CAM_AVG_ROUND_EN
    assign round_add = ACC_W'(cnt_q >> 1);
`else
    assign round_add = '0;
`endif

    always_comb begin
        for (int c = 0; c < NUM_CH; c++) begin
            pix_ch[c] = pixel[c*PIX_W +: PIX_W];
            div_in[c] = acc_q[c] + round_add;
        end
    end

    // One restoring-division step. The remainder is always below the divisor,
    // which is below 2^CNT_W, so the shifted remainder never needs the top bit
    // once the subtraction has been taken.
    assign div_ext   = ACC_W'(div_cnt_q);
    assign rem_shift = {rem_q, quo_q[ACC_W-1]};
    assign rem_ge    = (rem_shift >= {1'b0, div_ext});
    assign rem_sub   = rem_shift[ACC_W-1:0] - div_ext;
    assign rem_next  = rem_ge ? rem_sub : rem_shift[ACC_W-1:0];
    assign quo_next  = {quo_q[ACC_W-2:0], rem_ge};
    assign last_bit  = (bit_q == BIT_LAST);
    assign last_ch   = (ch_q == CH_LAST);
    assign ch_nxt    = ch_q + 1'b1;

    function automatic logic [PIX_W-1:0] sat(input logic [ACC_W-1:0] q);
        return (|q[ACC_W-1:PIX_W]) ? {PIX_W{1'b1}} : q[PIX_W-1:0];
    endfunction

    // -------------------------------------------------------------------------
    // FSM
    // -------------------------------------------------------------------------
    always_ff @(posedge VGA_CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= S_IDLE;
        end else begin
            // NOTE: clocked state uses non-blocking assignments so every flop
            // samples pre-edge values regardless of statement order.
            state_q <= state_d;
        end
    end

    always_comb begin
        // NOTE: default assigned first so no path leaves state_d unassigned,
        // which would otherwise infer a latch.
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start_div) state_d = S_DIV;
            S_DIV:   if (last_bit && last_ch) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // -------------------------------------------------------------------------
    // Datapath
    // -------------------------------------------------------------------------
    always_ff @(posedge VGA_CLK or negedge RST_N) begin
        if (!RST_N) begin
            vs_q        <= 1'b1;
            cnt_q       <= '0;
            fcnt_q      <= '0;
            div_cnt_q   <= '0;
            rem_q       <= '0;
            quo_q       <= '0;
            bit_q       <= '0;
            ch_q        <= '0;
            color_q     <= '0;
            upd_q       <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
            // NOTE: these arrays are a handful of flops, not RAM, so they are
            // reset like any other register and a reset aborts a division.
            for (int c = 0; c < NUM_CH; c++) begin
                acc_q[c]  <= '0;
                snap_q[c] <= '0;
                res_q[c]  <= '0;
            end
        end else begin
            vs_q <= V_SYNC;

            // Accumulation runs independently of the divider.
            if (boundary) begin
                for (int c = 0; c < NUM_CH; c++) begin
                    acc_q[c] <= pix_valid ? ACC_W'(pix_ch[c]) : '0;
                end
                cnt_q  <= pix_valid ? CNT_W'(1) : '0;
                fcnt_q <= upd_due ? '0 : fcnt_q + 1'b1;
            end else if (pix_valid) begin
                if (cnt_q != FRAME_PIX_C) begin
                    for (int c = 0; c < NUM_CH; c++) begin
                        acc_q[c] <= acc_q[c] + ACC_W'(pix_ch[c]);
                    end
                    cnt_q <= cnt_q + 1'b1;
                end else begin
                    frame_err_q <= 1'b1;
                end
            end

            if (upd_due && busy) begin
                overrun_q <= 1'b1;
            end

            case (state_q)
                S_IDLE: begin
                    if (start_div) begin
                        for (int c = 0; c < NUM_CH; c++) begin
                            snap_q[c] <= div_in[c];
                        end
                        div_cnt_q <= cnt_q;
                        rem_q     <= '0;
                        quo_q     <= div_in[0];
                        bit_q     <= '0;
                        ch_q      <= '0;
                    end
                end
                S_DIV: begin
                    rem_q <= rem_next;
                    quo_q <= quo_next;
                    bit_q <= bit_q + 1'b1;
                    if (last_bit) begin
                        res_q[ch_q] <= quo_next;
                        rem_q       <= '0;
                        bit_q       <= '0;
                        if (!last_ch) begin
                            ch_q  <= ch_nxt;
                            quo_q <= snap_q[ch_nxt];
                        end
                    end
                end
                S_DONE: begin
                    // All channels change together with the upd toggle.
                    for (int c = 0; c < NUM_CH; c++) begin
                        color_q[c*PIX_W +: PIX_W] <= sat(res_q[c]);
                    end
                    upd_q <= ~upd_q;
                end
                default: ;
            endcase
        end
    end

    assign color     = color_q;
    assign upd       = upd_q;
    assign frame_err = frame_err_q;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_cam_avg_multi.sv
// -----------------------------------------------------------------------------
// tb_cam_avg_multi
//
// Two instances with FRAME_PIX=16, NUM_CH=3, ACC_W=16: dut uses
// FRAMES_PER_UPD=2, dut_ovr uses FRAMES_PER_UPD=1 for the overrun scenario.
// Stimulus tasks push expected averages into a queue per instance; a monitor
// pops and compares whenever the instance toggles upd.
// -----------------------------------------------------------------------------
module tb_cam_avg_multi;

    localparam int PIX_W     = 8;
    localparam int NUM_CH    = 3;
    localparam int FRAME_PIX = 16;
    localparam int ACC_W     = 16;
    localparam int FPU       = 2;
    localparam int LATENCY   = NUM_CH * ACC_W + 2;

`ifdef CAM_AVG_ROUND_EN
    localparam bit ROUND = 1'b1;
`else
    localparam bit ROUND = 1'b0;
`endif

    logic        clk       = 1'b0;
    logic        rst_n     = 1'b1;
    logic        v_sync    = 1'b1;
    logic        pix_valid = 1'b0;
    logic [23:0] pixel     = '0;
    logic [23:0] color;
    logic        upd, busy, frame_err, overrun;

    logic        v_sync2    = 1'b1;
    logic        pix_valid2 = 1'b0;
    logic [23:0] pixel2     = '0;
    logic [23:0] color2;
    logic        upd2, busy2, frame_err2, overrun2;

    int n_tests  = 0;
    int n_fail   = 0;
    int toggles2 = 0;

    int unsigned m_sum [NUM_CH];
    int          m_cnt  = 0;
    int          m_fcnt = 0;

    logic [23:0] exp_q  [$];
    logic [23:0] exp2_q [$];
    logic [23:0] mon_e, mon_e2;
    logic        upd_prev  = 1'b0;
    logic        upd2_prev = 1'b0;

    always #5 clk = ~clk;

    cam_avg_multi #(
        .PIX_W(PIX_W), .NUM_CH(NUM_CH), .FRAME_PIX(FRAME_PIX),
        .FRAMES_PER_UPD(FPU), .ACC_W(ACC_W)
    ) dut (
        .VGA_CLK(clk), .RST_N(rst_n), .V_SYNC(v_sync), .pix_valid(pix_valid),
        .pixel(pixel), .color(color), .upd(upd), .busy(busy),
        .frame_err(frame_err), .overrun(overrun)
    );

    cam_avg_multi #(
        .PIX_W(PIX_W), .NUM_CH(NUM_CH), .FRAME_PIX(FRAME_PIX),
        .FRAMES_PER_UPD(1), .ACC_W(ACC_W)
    ) dut_ovr (
        .VGA_CLK(clk), .RST_N(rst_n), .V_SYNC(v_sync2), .pix_valid(pix_valid2),
        .pixel(pixel2), .color(color2), .upd(upd2), .busy(busy2),
        .frame_err(frame_err2), .overrun(overrun2)
    );

    // Scoreboard monitor: every upd toggle consumes one expected average.
    always @(negedge clk) begin
        if (!rst_n) begin
            upd_prev  = 1'b0;
            upd2_prev = 1'b0;
        end else begin
            if (upd !== upd_prev) begin
                upd_prev = upd;
                n_tests++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL sb_unexpected_upd: color=%h, nothing expected", color);
                end else begin
                    mon_e = exp_q.pop_front();
                    if (color !== mon_e) begin
                        n_fail++;
                        $display("FAIL sb_color: got %h expected %h", color, mon_e);
                    end
                end
            end
            if (upd2 !== upd2_prev) begin
                upd2_prev = upd2;
                toggles2++;
                n_tests++;
                if (exp2_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL sb2_unexpected_upd: color=%h, nothing expected", color2);
                end else begin
                    mon_e2 = exp2_q.pop_front();
                    if (color2 !== mon_e2) begin
                        n_fail++;
                        $display("FAIL sb2_color: got %h expected %h", color2, mon_e2);
                    end
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------------------------------------------------------- model
    function automatic logic [23:0] model_avg();
        logic [23:0] r;
        int unsigned q;
        r = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            q = m_sum[c];
            if (ROUND) q = q + m_cnt / 2;
            q = q / m_cnt;
            if (q > 255) q = 255;
            r[c*8 +: 8] = 8'(q);
        end
        return r;
    endfunction

    task automatic model_clear_frame();
        for (int c = 0; c < NUM_CH; c++) m_sum[c] = 0;
        m_cnt = 0;
    endtask

    // ---------------------------------------------------------------- drivers
    // All drivers start and end on a falling clock edge.
    task automatic pix(input logic [23:0] p);
        pixel     = p;
        pix_valid = 1'b1;
        if (m_cnt < FRAME_PIX) begin
            for (int c = 0; c < NUM_CH; c++) m_sum[c] += p[c*8 +: 8];
            m_cnt++;
        end
        @(negedge clk);
        pix_valid = 1'b0;
    endtask

    task automatic boundary();
        v_sync    = 1'b0;
        pix_valid = 1'b0;
        if (m_fcnt == FPU - 1) begin
            m_fcnt = 0;
            if (m_cnt > 0) exp_q.push_back(model_avg());
        end else begin
            m_fcnt++;
        end
        model_clear_frame();
        @(negedge clk);
        v_sync = 1'b1;
    endtask

    task automatic pix2(input logic [23:0] p);
        pixel2     = p;
        pix_valid2 = 1'b1;
        @(negedge clk);
        pix_valid2 = 1'b0;
    endtask

    task automatic boundary2();
        v_sync2 = 1'b0;
        @(negedge clk);
        v_sync2 = 1'b1;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n      = 1'b0;
        v_sync     = 1'b1;
        pix_valid  = 1'b0;
        v_sync2    = 1'b1;
        pix_valid2 = 1'b0;
        repeat (2) @(negedge clk);
        exp_q.delete();
        exp2_q.delete();
        model_clear_frame();
        m_fcnt   = 0;
        toggles2 = 0;
        rst_n    = 1'b1;
        @(negedge clk);
    endtask

    // Waits (bounded) for dut.upd to leave 'old'; n = falling edges waited.
    task automatic wait_upd(input string name, input logic old, output int n);
        n = 0;
        while (upd === old && n < 200) begin
            @(negedge clk);
            n++;
        end
        n_tests++;
        if (upd === old) begin
            n_fail++;
            $display("FAIL %s: upd still %b after %0d cycles, toggle required", name, upd, n);
        end
    endtask

    // ---------------------------------------------------------------- tests
    task automatic test_reset();
        #1 rst_n = 1'b0;
        #2;
        n_tests++;
        if ({color, upd, busy, frame_err, overrun} !== 28'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %h/%b%b%b%b required all zero",
                     color, upd, busy, frame_err, overrun);
        end
        n_tests++;
        if ({color2, upd2, busy2, frame_err2, overrun2} !== 28'd0) begin
            n_fail++;
            $display("FAIL reset_outputs2: got %h/%b%b%b%b required all zero",
                     color2, upd2, busy2, frame_err2, overrun2);
        end
        @(negedge clk);
        rst_n = 1'b1;
        idle(5);
        n_tests++;
        if ({upd, busy} !== 2'b00) begin
            n_fail++;
            $display("FAIL reset_idle: upd,busy=%b%b required 00", upd, busy);
        end
    endtask

    task automatic test_flat();
        logic old;
        int   n;
        do_reset();
        repeat (16) pix({8'd30, 8'd20, 8'd10});
        boundary();
        repeat (16) pix({8'd30, 8'd20, 8'd10});
        old = upd;
        boundary();
        n_tests++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL flat_busy_rise: busy=%b required 1", busy);
        end
        // The boundary cycle itself is the first cycle of the latency.
        n = 1;
        while (upd === old && n < 200) begin
            @(negedge clk);
            n++;
        end
        n_tests++;
        if (n !== LATENCY) begin
            n_fail++;
            $display("FAIL flat_latency: got %0d cycles required %0d", n, LATENCY);
        end
        n_tests++;
        if (color !== {8'd30, 8'd20, 8'd10}) begin
            n_fail++;
            $display("FAIL flat_color: got %h required 1e140a", color);
        end
        n_tests++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL flat_busy_fall: busy=%b required 0", busy);
        end
    endtask

    task automatic test_reset_mid_div();
        repeat (16) pix({8'd100, 8'd150, 8'd200});
        boundary();
        repeat (16) pix({8'd100, 8'd150, 8'd200});
        boundary();
        idle(20);
        n_tests++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL middiv_busy: busy=%b required 1", busy);
        end
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        n_tests++;
        if ({color, upd, busy, frame_err, overrun} !== 28'd0) begin
            n_fail++;
            $display("FAIL middiv_reset_outputs: got %h/%b%b%b%b required all zero",
                     color, upd, busy, frame_err, overrun);
        end
        repeat (2) @(negedge clk);
        exp_q.delete();
        model_clear_frame();
        m_fcnt = 0;
        rst_n  = 1'b1;
        idle(100);
        n_tests++;
        if ({color, upd, busy} !== 26'd0) begin
            n_fail++;
            $display("FAIL middiv_after_release: color=%h upd=%b busy=%b required 0",
                     color, upd, busy);
        end
    endtask

    task automatic test_rounding();
        logic       old;
        int         n;
        logic [7:0] exp_ch0;
        do_reset();
        boundary();
        for (int i = 0; i < 16; i++) pix({8'd200, 8'(i * 3), 8'(i)});
        old = upd;
        boundary();
        wait_upd("round_wait", old, n);
        exp_ch0 = ROUND ? 8'd8 : 8'd7;
        n_tests++;
        if (color[7:0] !== exp_ch0) begin
            n_fail++;
            $display("FAIL round_ch0: got %0d required %0d", color[7:0], exp_ch0);
        end
    endtask

    task automatic test_overflow();
        logic       old;
        int         n;
        logic [7:0] exp_ch0;
        do_reset();
        boundary();
        for (int k = 0; k < 16; k++) pix({8'(k * 2 + 100), 8'(255 - k), 8'(k * 7 + 1)});
        n_tests++;
        if (frame_err !== 1'b0) begin
            n_fail++;
            $display("FAIL ovf_at_limit: frame_err=%b required 0", frame_err);
        end
        repeat (4) pix(24'hFFFFFF);
        n_tests++;
        if (frame_err !== 1'b1) begin
            n_fail++;
            $display("FAIL ovf_flag: frame_err=%b required 1", frame_err);
        end
        old = upd;
        boundary();
        wait_upd("ovf_wait", old, n);
        exp_ch0 = ROUND ? 8'd54 : 8'd53;
        n_tests++;
        if (color[7:0] !== exp_ch0) begin
            n_fail++;
            $display("FAIL ovf_ch0: got %0d required %0d", color[7:0], exp_ch0);
        end
        n_tests++;
        if ({frame_err, overrun} !== 2'b10) begin
            n_fail++;
            $display("FAIL ovf_sticky: frame_err,overrun=%b%b required 10", frame_err, overrun);
        end
    endtask

    task automatic test_empty();
        logic [23:0] saved_color;
        logic        saved_upd;
        int          busy_seen;
        saved_color = color;
        saved_upd   = upd;
        busy_seen   = 0;
        boundary();
        idle(5);
        boundary();
        repeat (60) begin
            if (busy !== 1'b0) busy_seen++;
            @(negedge clk);
        end
        n_tests++;
        if (busy_seen !== 0) begin
            n_fail++;
            $display("FAIL empty_busy: busy high for %0d cycles required 0", busy_seen);
        end
        n_tests++;
        if ({color, upd} !== {saved_color, saved_upd}) begin
            n_fail++;
            $display("FAIL empty_unchanged: color=%h upd=%b required %h %b",
                     color, upd, saved_color, saved_upd);
        end
        n_tests++;
        if (overrun !== 1'b0) begin
            n_fail++;
            $display("FAIL empty_overrun: overrun=%b required 0", overrun);
        end
    endtask

    task automatic test_overrun();
        int n;
        do_reset();
        repeat (4) pix2({8'd70, 8'd60, 8'd50});
        exp2_q.push_back({8'd70, 8'd60, 8'd50});
        boundary2();
        n_tests++;
        if ({busy2, overrun2} !== 2'b10) begin
            n_fail++;
            $display("FAIL ovr_first: busy,overrun=%b%b required 10", busy2, overrun2);
        end
        // Four more boundaries 10 cycles apart, all inside the running division.
        for (int b = 0; b < 4; b++) begin
            repeat (2) pix2({8'd1, 8'd2, 8'd3});
            idle(7);
            boundary2();
            if (b == 0) begin
                n_tests++;
                if (overrun2 !== 1'b1) begin
                    n_fail++;
                    $display("FAIL ovr_flag: overrun=%b required 1", overrun2);
                end
            end
        end
        n = 0;
        while (toggles2 < 1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        idle(100);
        n_tests++;
        if (toggles2 !== 1 || exp2_q.size() !== 0 || busy2 !== 1'b0) begin
            n_fail++;
            $display("FAIL ovr_one_toggle: toggles=%0d pending=%0d busy=%b required 1 0 0",
                     toggles2, exp2_q.size(), busy2);
        end
        repeat (4) pix2({8'd90, 8'd80, 8'd70});
        exp2_q.push_back({8'd90, 8'd80, 8'd70});
        boundary2();
        n = 0;
        while (toggles2 < 2 && n < 200) begin
            @(negedge clk);
            n++;
        end
        n_tests++;
        if (toggles2 !== 2 || color2 !== {8'd90, 8'd80, 8'd70}) begin
            n_fail++;
            $display("FAIL ovr_next_update: toggles=%0d color=%h required 2 5a5046",
                     toggles2, color2);
        end
        n_tests++;
        if ({overrun2, frame_err2} !== 2'b10) begin
            n_fail++;
            $display("FAIL ovr_sticky: overrun,frame_err=%b%b required 10", overrun2, frame_err2);
        end
    endtask

    initial begin
        test_reset();
        test_flat();
        test_reset_mid_div();
        test_rounding();
        test_overflow();
        test_empty();
        test_overrun();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
